// File: rtl/prog_load_ctrl.sv
// Program-load sequencer: unpacks the host word stream into imem lines and dmem words,
// holds the core in reset while loading, then hands both memory ports to the core.
// Optional trailer checksum state is enabled by defining PLOAD_CSUM_EN.
module prog_load_ctrl #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32,
    parameter int IMEM_AW  = 9,
    parameter int DMEM_AW  = 12
) (
    input  logic                  clk,
    input  logic                  reset_x,
    input  logic                  start,
    input  logic                  ld_valid,
    input  logic [DATA_LEN-1:0]   ld_data,
    output logic                  ld_ready,
    output logic                  core_reset,
    output logic                  done,
    output logic                  err,
    input  logic [ADDR_LEN-1:0]   core_pc,
    input  logic                  core_dmem_we,
    input  logic [ADDR_LEN-1:0]   core_dmem_addr,
    input  logic [DATA_LEN-1:0]   core_dmem_wdata,
    output logic [IMEM_AW-1:0]    imem_addr,
    output logic                  imem_we,
    output logic [4*DATA_LEN-1:0] imem_wdata,
    output logic [ADDR_LEN-1:0]   dmem_addr,
    output logic                  dmem_we,
    output logic [DATA_LEN-1:0]   dmem_wdata
);

`ifdef PLOAD_CSUM_EN
    typedef enum logic [2:0] {
        S_HDR_I, S_LOAD_I, S_HDR_D, S_LOAD_D, S_DONE, S_ERR, S_CSUM
    } state_t;
    localparam state_t S_AFTER_D = S_CSUM;
`else
    typedef enum logic [2:0] {
        S_HDR_I, S_LOAD_I, S_HDR_D, S_LOAD_D, S_DONE, S_ERR
    } state_t;
    localparam state_t S_AFTER_D = S_DONE;
`endif

    localparam logic [DATA_LEN-1:0] I_MAX = DATA_LEN'(1) << IMEM_AW;
    localparam logic [DATA_LEN-1:0] D_MAX = DATA_LEN'(1) << DMEM_AW;
    localparam logic [IMEM_AW-1:0]  I_ONE = IMEM_AW'(1);
    localparam logic [DMEM_AW-1:0]  D_ONE = DMEM_AW'(1);

    state_t state, state_next;

    logic                  accept;
    logic [IMEM_AW-1:0]    line_idx, last_line;
    logic [1:0]            lane;
    logic [DMEM_AW-1:0]    word_idx, last_word;
    logic [3*DATA_LEN-1:0] pack;

    logic                  ld_imem_we;
    logic [IMEM_AW-1:0]    ld_imem_addr;
    logic [4*DATA_LEN-1:0] ld_imem_wdata;
    logic                  ld_dmem_we;
    logic [ADDR_LEN-1:0]   ld_dmem_addr;
    logic [DATA_LEN-1:0]   ld_dmem_wdata;

`ifdef PLOAD_CSUM_EN
    logic [DATA_LEN-1:0]   sum;
`endif

    logic unused_core_pc;
    assign unused_core_pc = ^{core_pc[ADDR_LEN-1:IMEM_AW+4], core_pc[3:0]};

    assign accept = ld_valid && ld_ready;

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) state <= S_HDR_I;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        ld_ready   = 1'b0;
        unique case (state)
            S_HDR_I: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    if (ld_data > I_MAX)     state_next = S_ERR;
                    else if (ld_data == '0)  state_next = S_HDR_D;
                    else                     state_next = S_LOAD_I;
                end
            end
            S_LOAD_I: begin
                ld_ready = 1'b1;
                if (ld_valid && lane == 2'd3 && line_idx == last_line)
                    state_next = S_HDR_D;
            end
            S_HDR_D: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    if (ld_data > D_MAX)     state_next = S_ERR;
                    else if (ld_data == '0)  state_next = S_AFTER_D;
                    else                     state_next = S_LOAD_D;
                end
            end
            S_LOAD_D: begin
                ld_ready = 1'b1;
                if (ld_valid && word_idx == last_word)
                    state_next = S_AFTER_D;
            end
`ifdef PLOAD_CSUM_EN
            S_CSUM: begin
                ld_ready = 1'b1;
                if (ld_valid)
                    state_next = (ld_data == sum) ? S_DONE : S_ERR;
            end
`endif
            S_DONE, S_ERR: begin
                if (start) state_next = S_HDR_I;
            end
            default: state_next = S_HDR_I;
        endcase
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            core_reset    <= 1'b1;
            line_idx      <= '0;
            last_line     <= '0;
            lane          <= '0;
            word_idx      <= '0;
            last_word     <= '0;
            pack          <= '0;
            ld_imem_we    <= 1'b0;
            ld_imem_addr  <= '0;
            ld_imem_wdata <= '0;
            ld_dmem_we    <= 1'b0;
            ld_dmem_addr  <= '0;
            ld_dmem_wdata <= '0;
`ifdef PLOAD_CSUM_EN
            sum           <= '0;
`endif
        end else begin
            ld_imem_we <= 1'b0;
            ld_dmem_we <= 1'b0;
            // Falls one cycle after DONE so the final load write completes under reset
            core_reset <= (state != S_DONE);
            if ((state == S_DONE || state == S_ERR) && start) begin
                line_idx <= '0;
                lane     <= '0;
                word_idx <= '0;
                pack     <= '0;
`ifdef PLOAD_CSUM_EN
                sum      <= '0;
`endif
            end
            if (accept) begin
`ifdef PLOAD_CSUM_EN
                if (state != S_CSUM) sum <= sum + ld_data;
`endif
                case (state)
                    S_HDR_I: begin
                        last_line <= ld_data[IMEM_AW-1:0] - I_ONE;
                        line_idx  <= '0;
                        lane      <= '0;
                    end
                    S_LOAD_I: begin
                        pack <= {pack[2*DATA_LEN-1:0], ld_data};
                        lane <= lane + 2'd1;
                        if (lane == 2'd3) begin
                            ld_imem_we    <= 1'b1;
                            ld_imem_addr  <= line_idx;
                            ld_imem_wdata <= {pack, ld_data};
                            line_idx      <= line_idx + I_ONE;
                        end
                    end
                    S_HDR_D: begin
                        last_word <= ld_data[DMEM_AW-1:0] - D_ONE;
                        word_idx  <= '0;
                    end
                    S_LOAD_D: begin
                        ld_dmem_we    <= 1'b1;
                        ld_dmem_addr  <= {{(ADDR_LEN-DMEM_AW-2){1'b0}}, word_idx, 2'b00};
                        ld_dmem_wdata <= ld_data;
                        word_idx      <= word_idx + D_ONE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign done = (state == S_DONE) && !core_reset;
    assign err  = (state == S_ERR);

    always_comb begin
        if (core_reset) begin
            imem_addr  = ld_imem_addr;
            imem_we    = ld_imem_we;
            imem_wdata = ld_imem_wdata;
            dmem_addr  = ld_dmem_addr;
            dmem_we    = ld_dmem_we;
            dmem_wdata = ld_dmem_wdata;
        end else begin
            imem_addr  = core_pc[IMEM_AW+3:4];
            imem_we    = 1'b0;
            imem_wdata = '0;
            dmem_addr  = core_dmem_addr;
            dmem_we    = core_dmem_we;
            dmem_wdata = core_dmem_wdata;
        end
    end

endmodule

// File: doc/prog_load_ctrl.md
Name: prog_load_ctrl

Overview:
- Program-load sequencer and memory-port arbiter between the host loader stream and the pipeline core.
- Consumes a 32-bit word stream (valid/ready), packs it into 128-bit imem lines and 32-bit dmem words, and writes both memories.
- Holds the core in reset while loading, then hands the imem/dmem ports to the core.
- Replaces the fixed prog_loading register and the ad-hoc muxes in the top level.

Parameters:
ADDR_LEN, 32, byte-address width of core dmem/pc addresses
DATA_LEN, 32, dmem word width and stream word width
IMEM_AW, 9, imem line-index width (lines of 4 instructions)
DMEM_AW, 12, dmem word-index width; load capacity is 2^DMEM_AW words

Ports:
clk  in  1  clock
reset_x  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; restarts a load from DONE or ERR, ignored otherwise
ld_valid  in  1  stream word valid
ld_data  in  DATA_LEN  stream word
ld_ready  out  1  stream ready
core_reset  out  1  reset to the pipeline, high while loading
done  out  1  load completed, core running
err  out  1  load aborted
core_pc  in  ADDR_LEN  core fetch pc
core_dmem_we  in  1  core store strobe
core_dmem_addr  in  ADDR_LEN  core byte address
core_dmem_wdata  in  DATA_LEN  core store data
imem_addr  out  IMEM_AW  imem address (shared read/write index)
imem_we  out  1  imem line write
imem_wdata  out  4*DATA_LEN  imem line data
dmem_addr  out  ADDR_LEN  dmem byte address
dmem_we  out  1  dmem write
dmem_wdata  out  DATA_LEN  dmem write data

Behaviour:
- Stream format: N_I (line count); 4*N_I instruction words; N_D (word count); N_D data words.
- Packing: within a line, the first word lands in [127:96], the 4th in [31:0].
- Handshake: a word is accepted on a clk edge with ld_valid && ld_ready. ld_ready=1 only in HDR_I, LOAD_I, HDR_D, LOAD_D. No backpressure otherwise; writes never stall the stream.
- States: HDR_I, LOAD_I, HDR_D, LOAD_D, DONE, ERR. Reset enters HDR_I.
- HDR_I: accept N_I.
  - N_I > 2^IMEM_AW -> ERR.
  - N_I = 0 -> HDR_D.
  - otherwise -> LOAD_I, line index 0, lane 0.
- LOAD_I: 2-bit lane counter.
  - On the 4th accepted word, imem_we pulses 1 cycle the cycle after acceptance, with imem_addr = line index and imem_wdata = packed line; line index then increments.
  - After line N_I-1 -> HDR_D.
- HDR_D: accept N_D.
  - N_D > 2^DMEM_AW -> ERR.
  - N_D = 0 -> DONE (or CSUM state).
  - otherwise -> LOAD_D, word index 0.
- LOAD_D: each accepted word gives dmem_we=1 the next cycle, dmem_addr = {index,2'b00} zero-extended, dmem_wdata = word. After word N_D-1 -> DONE.
- Write strobes are registered: at most one imem or dmem write per cycle, never both.
- core_reset: register, set by reset, set on any entry to HDR_I; next value = (state != DONE). It falls one cycle after DONE is entered, so the last load write never overlaps the core.
- done = (state == DONE) && !core_reset.
- err = (state == ERR). In ERR: ld_ready=0, core_reset=1.
- Port mux, selected by core_reset:
  - 1: loader drives imem_addr/imem_we/imem_wdata and dmem_*.
  - 0: imem_addr = core_pc[IMEM_AW+3:4], imem_we=0, imem_wdata=0; dmem_* = core_*.
- Reset values: core_reset=1, done=0, err=0, imem_we=0, dmem_we=0, ld_ready=1, counters 0, packing register 0.
- Boundary cases:
  - start in DONE or ERR -> HDR_I next cycle, core_reset=1 the following cycle, counters cleared.
  - start while loading is ignored.
  - reset_x low mid-load aborts immediately and asynchronously to the reset state; partial memory contents are left as-is.
  - N_I = 2^IMEM_AW is legal; the line index wraps to 0 only after the final line.
  - ld_valid low mid-line holds lane state indefinitely.

Optional Feature:
PLOAD_CSUM_EN
- Defined: after the data payload (or after N_D when N_D = 0), state CSUM accepts one trailer word.
  - Trailer == 32-bit wrapping sum of all preceding stream words (headers included) -> DONE.
  - Otherwise -> ERR.
  - The sum register clears on entry to HDR_I.
- Undefined: no CSUM state and no sum register; LOAD_D/HDR_D go straight to DONE.

Test Plan:
- Stream 1, 0x11,0x22,0x33,0x44, 0 with ld_valid held high -> one imem_we at line 0, data 0x00000011_00000022_00000033_00000044; no dmem_we; core_reset falls 2 cycles after the last word; done=1.
- Stream 0, 2, 0xA, 0xB -> dmem_we at addr 0 data 0xA, then addr 4 data 0xB; imem_we never asserted.
- Stream N_I=513 with IMEM_AW=9 -> err=1, ld_ready=0, core_reset=1; then start -> HDR_I, ld_ready=1, err=0.
- After done, drive core_dmem_we=1, addr 0x8, data 0x5 -> dmem outputs mirror the core; core_pc=0x30 -> imem_addr=3.
- reset_x pulsed low mid-LOAD_I (lane 2) -> imem_we=0 at once; the next stream restarts at header, line 0.
- With PLOAD_CSUM_EN: stream 0, 1, 0x10, trailer 0x11 -> DONE; trailer 0x12 -> ERR.
